// File: rtl/ps2_host_tx_if.sv
// rtl/ps2_host_tx_if.sv - command/status bundle between a requester and ps2_host_tx
//
// Purpose: groups the byte-request handshake and the completion status of the
// PS/2 host transmitter so both sides share a single port.
// Signals:
//   cmd_data  [7:0]  byte to transmit, sampled when the request is accepted
//   cmd_valid        request strobe, honoured only while the transmitter is idle
//   busy             transfer in progress
//   done             one-cycle pulse, byte sent and ACK seen
//   error            one-cycle pulse, missing ACK or timeout
// Modports:
//   master  drives the request, observes status (requester / testbench)
//   slave   observes the request, drives status (ps2_host_tx)

interface ps2_host_tx_if;
  logic [7:0] cmd_data;
  logic       cmd_valid;
  logic       busy;
  logic       done;
  logic       error;

  modport master (
    output cmd_data,
    output cmd_valid,
    input  busy,
    input  done,
    input  error
  );

  modport slave (
    input  cmd_data,
    input  cmd_valid,
    output busy,
    output done,
    output error
  );
endinterface

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter
//
// Purpose: sends one command byte to a PS/2 device. Inhibits the bus, issues
// request-to-send, shifts out 8 data bits LSB first, odd parity and stop on the
// device-generated clock, then checks the device ACK. The pins are open-drain;
// each *_oe output pulls its line low when 1.
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   bus          ps2_host_tx_if.slave: cmd_data/cmd_valid in, busy/done/error out
//   ps2_clk_in   raw PS/2 clock pin level
//   ps2_data_in  raw PS/2 data pin level
//   ps2_clk_oe   1 = pull clock line low
//   ps2_data_oe  1 = pull data line low

module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int RTS_CYCLES     = 100,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic           clk,
  input  logic           rst,
  ps2_host_tx_if.slave   bus,
  input  logic           ps2_clk_in,
  input  logic           ps2_data_in,
  output logic           ps2_clk_oe,
  output logic           ps2_data_oe
);

  // One counter serves the inhibit, RTS and timeout phases, so it is sized
  // for the largest of the three.
  localparam int MAX_AB = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
  localparam int MAX_C  = (TIMEOUT_CYCLES > MAX_AB) ? TIMEOUT_CYCLES : MAX_AB;
  localparam int CW     = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] RTS_LAST = CW'(RTS_CYCLES - 1);
  localparam logic [CW-1:0] TO_VAL   = CW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    SEND,
    ACK,
    WAIT_IDLE
  } state_t;

  // Pin synchronisers; reset to 1 so an idle bus never looks like a fall.
  logic [1:0] clk_sync;
  logic [1:0] data_sync;
  logic       clk_hist;
  logic       clk_s;
  logic       data_s;
  logic       fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_hist  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk_in};
      data_sync <= {data_sync[0], ps2_data_in};
      clk_hist  <= clk_sync[1];
    end
  end

  assign clk_s  = clk_sync[1];
  assign data_s = data_sync[1];
  assign fall   = clk_hist & ~clk_s;

  // Registered FSM state and datapath.
  state_t        state,     state_nxt;
  logic [CW-1:0] cnt,       cnt_nxt;
  logic [3:0]    bit_cnt,   bit_cnt_nxt;
  logic [7:0]    tx_byte,   tx_byte_nxt;
  logic          parity,    parity_nxt;
  logic          ack_ok,    ack_ok_nxt;
  logic          busy_q,    busy_nxt;
  logic          done_q,    done_nxt;
  logic          error_q,   error_nxt;
  logic          clk_oe_nxt;
  logic          data_oe_nxt;
  logic [CW-1:0] cnt_inc;
  logic          timeout;

  assign cnt_inc = cnt + CW'(1);
  assign timeout = (cnt_inc == TO_VAL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_cnt     <= '0;
      tx_byte     <= '0;
      parity      <= 1'b0;
      ack_ok      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      bit_cnt     <= bit_cnt_nxt;
      tx_byte     <= tx_byte_nxt;
      parity      <= parity_nxt;
      ack_ok      <= ack_ok_nxt;
      busy_q      <= busy_nxt;
      done_q      <= done_nxt;
      error_q     <= error_nxt;
      ps2_clk_oe  <= clk_oe_nxt;
      ps2_data_oe <= data_oe_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_cnt_nxt = bit_cnt;
    tx_byte_nxt = tx_byte;
    parity_nxt  = parity;
    ack_ok_nxt  = ack_ok;
    busy_nxt    = busy_q;
    clk_oe_nxt  = ps2_clk_oe;
    data_oe_nxt = ps2_data_oe;
    done_nxt    = 1'b0;
    error_nxt   = 1'b0;

    case (state)
      IDLE: begin
        clk_oe_nxt  = 1'b0;
        data_oe_nxt = 1'b0;
        busy_nxt    = 1'b0;
        if (bus.cmd_valid) begin
          tx_byte_nxt = bus.cmd_data;
          parity_nxt  = ~^bus.cmd_data;
          busy_nxt    = 1'b1;
          clk_oe_nxt  = 1'b1;
          cnt_nxt     = '0;
          state_nxt   = INHIBIT;
        end
      end

      INHIBIT: begin
        if (cnt == INH_LAST) begin
          cnt_nxt     = '0;
          data_oe_nxt = 1'b1;
          state_nxt   = RTS;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end

      // Data low is the start bit; releasing clock hands control to the device.
      RTS: begin
        if (cnt == RTS_LAST) begin
          clk_oe_nxt  = 1'b0;
          bit_cnt_nxt = '0;
          cnt_nxt     = '0;
          state_nxt   = SEND;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end

      // Data only moves on a fall so the device samples it stable on the rise.
      // A fall in the same cycle as a timeout takes priority.
      SEND: begin
        if (fall) begin
          cnt_nxt     = '0;
          bit_cnt_nxt = bit_cnt + 4'd1;
          if (bit_cnt < 4'd8) begin
            data_oe_nxt = ~tx_byte[bit_cnt[2:0]];
          end else if (bit_cnt == 4'd8) begin
            data_oe_nxt = ~parity;
          end else begin
            data_oe_nxt = 1'b0;
            state_nxt   = ACK;
          end
        end else if (timeout) begin
          error_nxt   = 1'b1;
          clk_oe_nxt  = 1'b0;
          data_oe_nxt = 1'b0;
          busy_nxt    = 1'b0;
          state_nxt   = IDLE;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end

      ACK: begin
        if (fall) begin
          cnt_nxt    = '0;
          ack_ok_nxt = ~data_s;
          state_nxt  = WAIT_IDLE;
        end else if (timeout) begin
          error_nxt   = 1'b1;
          clk_oe_nxt  = 1'b0;
          data_oe_nxt = 1'b0;
          busy_nxt    = 1'b0;
          state_nxt   = IDLE;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end

      // Result is reported only once the device has released both lines.
      WAIT_IDLE: begin
        if (clk_s && data_s) begin
          busy_nxt  = 1'b0;
          done_nxt  = ack_ok;
          error_nxt = ~ack_ok;
          state_nxt = IDLE;
        end else if (fall) begin
          cnt_nxt = '0;
        end else if (timeout) begin
          error_nxt   = 1'b1;
          clk_oe_nxt  = 1'b0;
          data_oe_nxt = 1'b0;
          busy_nxt    = 1'b0;
          state_nxt   = IDLE;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end

      default: begin
        clk_oe_nxt  = 1'b0;
        data_oe_nxt = 1'b0;
        busy_nxt    = 1'b0;
        state_nxt   = IDLE;
      end
    endcase
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.error = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - self-checking bench for ps2_host_tx with a PS/2 device model

module tb_ps2_host_tx;
  localparam int INH  = 50;
  localparam int RTSC = 10;
  localparam int TO   = 200;
  localparam int H    = 10;   // device clock half period in system cycles

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ps2_clk_oe;
  logic ps2_data_oe;
  logic dev_clk_low  = 1'b0;
  logic dev_data_low = 1'b0;
  wire  ps2_clk_line  = ~(ps2_clk_oe  | dev_clk_low);
  wire  ps2_data_line = ~(ps2_data_oe | dev_data_low);

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  ps2_host_tx_if bus();

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .RTS_CYCLES(RTSC),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .ps2_clk_in(ps2_clk_line),
    .ps2_data_in(ps2_data_line),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference frame as the device sees it on the data line: 8 data bits LSB
  // first, odd parity (total ones odd), stop bit high.
  function automatic logic [9:0] exp_frame(input logic [7:0] b);
    int ones;
    logic [9:0] f;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      f[i] = b[i];
      ones += int'(b[i]);
    end
    f[8] = (ones % 2 == 0);
    f[9] = 1'b1;
    return f;
  endfunction

  task automatic send_cmd(input logic [7:0] b);
    @(negedge clk);
    bus.cmd_data  = b;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  // Device: waits for RTS (clock released, data low), then produces n falls.
  task automatic dev_run(input int n, input bit ack, output logic [9:0] frame, output int fall_cyc);
    int w;
    frame = '0;
    fall_cyc = 0;
    w = 0;
    while (!(ps2_clk_line === 1'b1 && ps2_data_line === 1'b0) && w < 1000) begin
      @(negedge clk);
      w++;
    end
    vectors++;
    if (w >= 1000) begin
      miscompares++;
      $display("FAIL dev_start: no RTS seen after %0d cycles (required within 1000)", w);
      return;
    end
    repeat (H) @(negedge clk);
    for (int i = 1; i <= n; i++) begin
      if (i == 11 && ack) begin
        dev_data_low = 1'b1;
        repeat (2) @(negedge clk);
      end
      dev_clk_low = 1'b1;
      fall_cyc = cyc;
      repeat (H) @(negedge clk);
      if (i <= 10) frame[i-1] = ps2_data_line;
      dev_clk_low  = 1'b0;
      dev_data_low = 1'b0;
      if (i < n) repeat (H) @(negedge clk);
    end
  endtask

  task automatic wait_result(input int win, output int n_done, output int n_err,
                             output logic busy_at, output logic busy_prev);
    logic pb;
    n_done = 0;
    n_err = 0;
    busy_at = 1'bx;
    busy_prev = 1'bx;
    pb = bus.busy;
    repeat (win) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.error === 1'b1) begin
        busy_at = bus.busy;
        busy_prev = pb;
      end
      if (bus.done === 1'b1) n_done++;
      if (bus.error === 1'b1) n_err++;
      pb = bus.busy;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({bus.busy, bus.done, bus.error, ps2_clk_oe, ps2_data_oe} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_hold: outputs %b required 00000",
               {bus.busy, bus.done, bus.error, ps2_clk_oe, ps2_data_oe});
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({bus.busy, bus.done, bus.error, ps2_clk_oe, ps2_data_oe} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_idle: outputs %b required 00000",
               {bus.busy, bus.done, bus.error, ps2_clk_oe, ps2_data_oe});
    end
    // Asynchronous abort during the inhibit phase.
    send_cmd(8'h55);
    repeat (10) @(negedge clk);
    vectors++;
    if (ps2_clk_oe !== 1'b1) begin
      miscompares++;
      $display("FAIL inhibit_clk_oe: got %b required 1", ps2_clk_oe);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({ps2_clk_oe, ps2_data_oe, bus.busy} !== 3'b0) begin
      miscompares++;
      $display("FAIL async_reset_inhibit: clk_oe/data_oe/busy %b required 000",
               {ps2_clk_oe, ps2_data_oe, bus.busy});
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_basic_ed;
    int n_inh, n_rts, n_done, n_err, fc;
    logic [9:0] fr;
    logic ba, bp;
    send_cmd(8'hED);
    vectors++;
    if (bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_after_accept: got %b required 1", bus.busy);
    end
    n_inh = 0;
    while (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b0 && n_inh < INH * 4) begin
      n_inh++;
      @(negedge clk);
    end
    vectors++;
    if (n_inh !== INH) begin
      miscompares++;
      $display("FAIL inhibit_len: got %0d cycles required %0d", n_inh, INH);
    end
    n_rts = 0;
    while (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b1 && n_rts < RTSC * 4) begin
      n_rts++;
      @(negedge clk);
    end
    vectors++;
    if (n_rts !== RTSC) begin
      miscompares++;
      $display("FAIL rts_len: got %0d cycles required %0d", n_rts, RTSC);
    end
    dev_run(11, 1'b1, fr, fc);
    vectors++;
    if (fr !== exp_frame(8'hED)) begin
      miscompares++;
      $display("FAIL frame_ed: got %b required %b", fr, exp_frame(8'hED));
    end
    wait_result(30, n_done, n_err, ba, bp);
    vectors++;
    if (n_done !== 1 || n_err !== 0) begin
      miscompares++;
      $display("FAIL result_ed: done %0d error %0d required 1 0", n_done, n_err);
    end
    vectors++;
    if (bp !== 1'b1 || ba !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_at_done: before %b at %b required 1 0", bp, ba);
    end
  endtask

  task automatic test_parity;
    logic [7:0] bytes [2];
    logic [9:0] fr, ef;
    int n_done, n_err, fc;
    logic ba, bp;
    bytes[0] = 8'h01;
    bytes[1] = 8'h00;
    for (int k = 0; k < 2; k++) begin
      send_cmd(bytes[k]);
      dev_run(11, 1'b1, fr, fc);
      ef = exp_frame(bytes[k]);
      vectors++;
      if (fr[8] !== ef[8]) begin
        miscompares++;
        $display("FAIL parity_%02h: got %b required %b", bytes[k], fr[8], ef[8]);
      end
      wait_result(30, n_done, n_err, ba, bp);
      vectors++;
      if (n_done !== 1 || n_err !== 0) begin
        miscompares++;
        $display("FAIL result_%02h: done %0d error %0d required 1 0", bytes[k], n_done, n_err);
      end
    end
  endtask

  task automatic test_nack;
    logic [9:0] fr;
    int n_done, n_err, fc;
    logic ba, bp;
    send_cmd(8'hFF);
    dev_run(11, 1'b0, fr, fc);
    wait_result(30, n_done, n_err, ba, bp);
    vectors++;
    if (n_done !== 0 || n_err !== 1 || ba !== 1'b0) begin
      miscompares++;
      $display("FAIL nack: done %0d error %0d busy %b required 0 1 0", n_done, n_err, ba);
    end
  endtask

  task automatic test_timeout;
    logic [9:0] fr;
    int fc, err_cyc, n_err, n_done;
    logic [2:0] oe_at;
    send_cmd(8'hF4);
    dev_run(4, 1'b0, fr, fc);
    err_cyc = -1;
    n_err = 0;
    n_done = 0;
    oe_at = 3'bxxx;
    repeat (TO + 50) begin
      @(negedge clk);
      if (bus.error === 1'b1) begin
        if (n_err == 0) begin
          err_cyc = cyc;
          oe_at = {ps2_clk_oe, ps2_data_oe, bus.busy};
        end
        n_err++;
      end
      if (bus.done === 1'b1) n_done++;
    end
    // A pin edge is acted on 3 cycles after it; the timeout runs from there.
    vectors++;
    if (err_cyc !== fc + 3 + TO) begin
      miscompares++;
      $display("FAIL timeout_time: error at cycle %0d required %0d", err_cyc, fc + 3 + TO);
    end
    vectors++;
    if (n_err !== 1 || n_done !== 0) begin
      miscompares++;
      $display("FAIL timeout_pulses: error %0d done %0d required 1 0", n_err, n_done);
    end
    vectors++;
    if (oe_at !== 3'b000) begin
      miscompares++;
      $display("FAIL timeout_outputs: clk_oe/data_oe/busy %b required 000", oe_at);
    end
  endtask

  task automatic test_busy_ignore;
    logic [9:0] fr;
    int n_done, n_err, fc, busy_seen;
    logic ba, bp;
    send_cmd(8'h12);
    bus.cmd_data  = 8'hAA;
    bus.cmd_valid = 1'b1;
    dev_run(11, 1'b1, fr, fc);
    bus.cmd_valid = 1'b0;
    vectors++;
    if (fr !== exp_frame(8'h12)) begin
      miscompares++;
      $display("FAIL ignore_frame: got %b required %b", fr, exp_frame(8'h12));
    end
    wait_result(30, n_done, n_err, ba, bp);
    vectors++;
    if (n_done !== 1 || n_err !== 0) begin
      miscompares++;
      $display("FAIL ignore_result: done %0d error %0d required 1 0", n_done, n_err);
    end
    busy_seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.busy !== 1'b0) busy_seen++;
    end
    vectors++;
    if (busy_seen !== 0) begin
      miscompares++;
      $display("FAIL not_queued: busy for %0d cycles required 0", busy_seen);
    end
    send_cmd(8'hAA);
    dev_run(11, 1'b1, fr, fc);
    vectors++;
    if (fr !== exp_frame(8'hAA)) begin
      miscompares++;
      $display("FAIL frame_aa: got %b required %b", fr, exp_frame(8'hAA));
    end
    wait_result(30, n_done, n_err, ba, bp);
    vectors++;
    if (n_done !== 1 || n_err !== 0) begin
      miscompares++;
      $display("FAIL result_aa: done %0d error %0d required 1 0", n_done, n_err);
    end
  endtask

  task automatic test_random;
    logic [7:0] b;
    logic [9:0] fr;
    bit ack;
    int n_done, n_err, fc;
    logic ba, bp;
    for (int k = 0; k < 6; k++) begin
      b = 8'($urandom);
      ack = ($urandom_range(0, 3) != 0);
      send_cmd(b);
      dev_run(11, ack, fr, fc);
      vectors++;
      if (fr !== exp_frame(b)) begin
        miscompares++;
        $display("FAIL rand_frame_%02h: got %b required %b", b, fr, exp_frame(b));
      end
      wait_result(30, n_done, n_err, ba, bp);
      vectors++;
      if (n_done !== int'(ack) || n_err !== int'(!ack) || ba !== 1'b0) begin
        miscompares++;
        $display("FAIL rand_result_%02h: done %0d error %0d busy %b required %0d %0d 0",
                 b, n_done, n_err, ba, int'(ack), int'(!ack));
      end
    end
  endtask

  task automatic test_reset_mid_send;
    logic [7:0] b;
    logic [9:0] fr;
    int fc, n_done, n_err;
    logic ba, bp;
    b = 8'($urandom) & 8'hEF;
    send_cmd(b);
    dev_run(5, 1'b0, fr, fc);
    repeat (2) @(negedge clk);
    vectors++;
    if (ps2_data_oe !== ~b[4]) begin
      miscompares++;
      $display("FAIL bit4_drive: data_oe %b required %b", ps2_data_oe, ~b[4]);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({ps2_clk_oe, ps2_data_oe, bus.busy} !== 3'b0) begin
      miscompares++;
      $display("FAIL async_reset_send: clk_oe/data_oe/busy %b required 000",
               {ps2_clk_oe, ps2_data_oe, bus.busy});
    end
    @(negedge clk);
    rst = 1'b0;
    wait_result(TO + 20, n_done, n_err, ba, bp);
    vectors++;
    if (n_done !== 0 || n_err !== 0) begin
      miscompares++;
      $display("FAIL reset_no_pulse: done %0d error %0d required 0 0", n_done, n_err);
    end
  endtask

  initial begin
    bus.cmd_data  = 8'h00;
    bus.cmd_valid = 1'b0;
    test_reset();
    test_basic_ed();
    test_parity();
    test_nack();
    test_timeout();
    test_busy_ignore();
    test_random();
    test_reset_mid_send();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
